// File: rtl/systolic_array_ctrl_param.sv
// systolic_array_ctrl_param
//   Controller for a ROWS x COLS output-stationary systolic MAC array.
//   One-cycle init request runs CLEAR -> RUN -> DONE. Per-PE clr/read/write
//   strobes follow a skewed diagonal wavefront: PE(i,j) accumulates for K
//   cycles starting at t=i+j and stores its result at t=i+j+K.
//   RUN lasts T = K+ROWS+COLS-1 cycles (t = 0..T-1).
//   Optional feature macro: SA_CTRL_BACKTOBACK_EN (init sampled in DONE
//   restarts directly into CLEAR, giving a T+2 cycle job period).
//   Outputs are flopped from the next-state decode, so they carry the same
//   cycle timing as a Moore decode of the registered state and counter.
module systolic_array_ctrl_param #(
    parameter int ROWS = 5,
    parameter int COLS = 5,
    parameter int K    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
    output logic [ROWS*COLS-1:0] read,
    output logic [ROWS*COLS-1:0] write,
    output logic [ROWS*COLS-1:0] clr,
    output logic                 busy,
    output logic                 done
);

    localparam int N  = ROWS * COLS;
    localparam int T  = K + ROWS + COLS - 1;
    localparam int TW = $clog2(T + 1);
    localparam logic [TW-1:0] T_LAST = TW'(T - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [TW-1:0] T_ZERO = TW'(0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic [N-1:0]  read_q, read_d;
    logic [N-1:0]  write_q, write_d;
    logic [N-1:0]  clr_q, clr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Accumulate window for every PE at wavefront time t: i+j <= t < i+j+K.
    function automatic logic [N-1:0] read_mask(input logic [TW-1:0] t);
        logic [N-1:0] m;
        int           tv;
        m  = {N{1'b0}};
        tv = int'(t);
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                m[i*COLS+j] = ((i + j) <= tv) && (tv < (i + j + K));
            end
        end
        return m;
    endfunction

    // Result-store strobe for every PE at wavefront time t: t == i+j+K.
    function automatic logic [N-1:0] write_mask(input logic [TW-1:0] t);
        logic [N-1:0] m;
        int           tv;
        m  = {N{1'b0}};
        tv = int'(t);
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                m[i*COLS+j] = (tv == (i + j + K));
            end
        end
        return m;
    endfunction

    // Next-state and wavefront counter logic.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            S_IDLE: begin
                t_d = T_ZERO;
                if (init) begin
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                state_d = S_RUN;
                t_d     = T_ZERO;
            end
            S_RUN: begin
                if (t_q == T_LAST) begin
                    state_d = S_DONE;
                    t_d     = T_ZERO;
                end else begin
                    state_d = S_RUN;
                    t_d     = t_q + T_ONE;
                end
            end
            S_DONE: begin
                t_d = T_ZERO;
`ifdef SA_CTRL_BACKTOBACK_EN
                if (init) begin
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
                t_d     = T_ZERO;
            end
        endcase
    end

    // Output decode of the upcoming state/counter, captured into output flops.
    always_comb begin
        read_d  = {N{1'b0}};
        write_d = {N{1'b0}};
        clr_d   = {N{1'b0}};
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            S_IDLE: begin
                busy_d = 1'b0;
            end
            S_CLEAR: begin
                clr_d  = {N{1'b1}};
                busy_d = 1'b1;
            end
            S_RUN: begin
                read_d  = read_mask(t_d);
                write_d = write_mask(t_d);
                busy_d  = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            t_q     <= T_ZERO;
            read_q  <= {N{1'b0}};
            write_q <= {N{1'b0}};
            clr_q   <= {N{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            read_q  <= read_d;
            write_q <= write_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign read  = read_q;
    assign write = write_q;
    assign clr   = clr_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_systolic_array_ctrl_param.sv
// Directed bench for systolic_array_ctrl_param: a 5x5/K=5 instance and a
// 2x3/K=4 instance. Honours SA_CTRL_BACKTOBACK_EN for the DONE-restart case.
module tb_systolic_array_ctrl_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        init;
    logic        init2;
    logic [24:0] read, write, clr;
    logic        busy, done;
    logic [5:0]  read2, write2, clr2;
    logic        busy2, done2;

    int checks   = 0;
    int failures = 0;

    systolic_array_ctrl_param #(.ROWS(5), .COLS(5), .K(5)) dut (
        .clk(clk), .rst(rst), .init(init),
        .read(read), .write(write), .clr(clr), .busy(busy), .done(done)
    );

    systolic_array_ctrl_param #(.ROWS(2), .COLS(3), .K(4)) dut2 (
        .clk(clk), .rst(rst), .init(init2),
        .read(read2), .write(write2), .clr(clr2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [24:0] rd;
        logic [24:0] wr;
        logic [24:0] cl;
        logic        bs;
        logic        dn;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int rd_cnt[25];
    int wr_cnt[25];
    int last_rd[25];
    int wr_n[25];

    initial begin
        int k;
        int ovl;
        int busy_cnt;
        int done_cnt;
        int w24;
        int seen;
        int got;

        // cycle n = number of edges since (and including) the init edge E0
        tbl[0] = '{1,  25'h0000000, 25'h0000000, 25'h1FFFFFF, 1'b1, 1'b0};
        tbl[1] = '{2,  25'h0000001, 25'h0000000, 25'h0000000, 1'b1, 1'b0};
        tbl[2] = '{3,  25'h0000023, 25'h0000000, 25'h0000000, 1'b1, 1'b0};
        tbl[3] = '{4,  25'h0000467, 25'h0000000, 25'h0000000, 1'b1, 1'b0};
        tbl[4] = '{7,  25'h033BFFE, 25'h0000001, 25'h0000000, 1'b1, 1'b0};
        tbl[5] = '{14, 25'h1000000, 25'h0880000, 25'h0000000, 1'b1, 1'b0};
        tbl[6] = '{15, 25'h0000000, 25'h1000000, 25'h0000000, 1'b1, 1'b0};
        tbl[7] = '{16, 25'h0000000, 25'h0000000, 25'h0000000, 1'b0, 1'b1};
        tbl[8] = '{17, 25'h0000000, 25'h0000000, 25'h0000000, 1'b0, 1'b0};

        // Reset held for two cycles
        rst = 1'b1; init = 1'b0; init2 = 1'b0;
        step(); step();
        chk("rst_read", 32'(read), 32'd0);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_clr", 32'(clr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_clr", 32'(clr), 32'd0);

        // Full 5x5 job, table-driven plus per-PE sequencing statistics
        for (int p = 0; p < 25; p++) begin
            rd_cnt[p] = 0; wr_cnt[p] = 0; last_rd[p] = -100; wr_n[p] = -1;
        end
        k = 0; ovl = 0; busy_cnt = 0; done_cnt = 0;
        init = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            step();
            init = 1'b0;
            if ((read & write) != 25'd0) ovl++;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            for (int p = 0; p < 25; p++) begin
                if (read[p]) begin rd_cnt[p]++; last_rd[p] = n; end
                if (write[p]) begin wr_cnt[p]++; wr_n[p] = n; end
            end
            if (k < 9 && tbl[k].n == n) begin
                chk($sformatf("job_read_n%0d", n), 32'(read), 32'(tbl[k].rd));
                chk($sformatf("job_write_n%0d", n), 32'(write), 32'(tbl[k].wr));
                chk($sformatf("job_clr_n%0d", n), 32'(clr), 32'(tbl[k].cl));
                chk($sformatf("job_busy_n%0d", n), 32'(busy), 32'(tbl[k].bs));
                chk($sformatf("job_done_n%0d", n), 32'(done), 32'(tbl[k].dn));
                k++;
            end
        end
        chk("job_overlap", 32'(ovl), 32'd0);
        chk("job_busy_cycles", 32'(busy_cnt), 32'd15);
        chk("job_done_pulses", 32'(done_cnt), 32'd1);
        for (int p = 0; p < 25; p++) begin
            chk($sformatf("pe%0d_reads", p), 32'(rd_cnt[p]), 32'd5);
            chk($sformatf("pe%0d_writes", p), 32'(wr_cnt[p]), 32'd1);
            chk($sformatf("pe%0d_write_after_read", p), 32'(wr_n[p]), 32'(last_rd[p] + 1));
        end

        // init during RUN ignored, then reset mid-run aborts
        step();
        init = 1'b1;
        step();                       // CLEAR
        init = 1'b0;
        step(); step(); step(); step(); // t=0..3
        init = 1'b1;
        step();                       // t=4
        init = 1'b0;
        chk("midrun_clr", 32'(clr), 32'd0);
        chk("midrun_busy", 32'(busy), 32'd1);
        chk("midrun_read_t4", 32'(read), 32'h0119DFF);
        chk("midrun_write_t4", 32'(write), 32'd0);
        step(); step(); step();       // t=5..7
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_read", 32'(read), 32'd0);
        chk("abort_write", 32'(write), 32'd0);
        chk("abort_clr", 32'(clr), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        w24 = 0; seen = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (write[24]) w24++;
            if (done || busy) seen++;
        end
        chk("abort_no_pe44_write", 32'(w24), 32'd0);
        chk("abort_no_activity", 32'(seen), 32'd0);

        // 2x3, K=4 instance (T=8)
        done_cnt = 0;
        init2 = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            step();
            init2 = 1'b0;
            if (done2) done_cnt++;
            if (n == 1) chk("small_clr", 32'(clr2), 32'h3F);
            if (n == 2) chk("small_read_t0", 32'(read2), 32'h01);
            if (n == 9) begin
                chk("small_write_t7", 32'(write2), 32'h20);
                chk("small_read_t7", 32'(read2), 32'h00);
            end
            if (n == 10) begin
                chk("small_done", 32'(done2), 32'd1);
                chk("small_busy_done", 32'(busy2), 32'd0);
            end
        end
        chk("small_done_pulses", 32'(done_cnt), 32'd1);

        // init held through DONE
        init = 1'b1;
        step();
        init = 1'b0;
        got = 0;
        for (int n = 0; n < 40 && got == 0; n++) begin
            step();
            if (done) got = 1;
        end
        chk("b2b_done_seen", 32'(got), 32'd1);
        init = 1'b1;
        step();
`ifdef SA_CTRL_BACKTOBACK_EN
        chk("b2b_clr_next", 32'(clr), 32'h1FFFFFF);
        chk("b2b_busy_next", 32'(busy), 32'd1);
`else
        chk("b2b_idle_clr", 32'(clr), 32'd0);
        chk("b2b_idle_busy", 32'(busy), 32'd0);
        step();
        chk("b2b_clr_resampled", 32'(clr), 32'h1FFFFFF);
`endif
        init = 1'b0;
        got = 0;
        for (int n = 0; n < 40 && got == 0; n++) begin
            step();
            if (done) got = 1;
        end
        chk("b2b_second_done", 32'(got), 32'd1);
        step();
        chk("final_idle_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
